// File: rtl/spi_sd_init_monitor.sv
// SD-over-SPI power-up monitor: counts dummy clocks, then frames
// 48-bit commands, checks CRC7 and reports index/argument.
module spi_sd_init_monitor #(
  parameter int MIN_DUMMY_CLKS = 74,
  parameter int CNT_WIDTH      = 8,
  parameter bit CS_ACTIVE_LOW  = 1'b1,
  parameter bit CHECK_CRC      = 1'b1
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 MOSI,
  input  logic                 CS,
  input  logic                 Rearm,
  output logic                 IsInitialized,
  output logic [CNT_WIDTH-1:0] DummyCount,
  output logic                 CmdValid,
  output logic [5:0]           CmdIndex,
  output logic [31:0]          CmdArg,
  output logic                 CmdCrcOk,
  output logic                 CmdError,
  output logic                 FrameAbort,
  output logic                 IsCmd0Received
);

  typedef enum logic [1:0] {
    COUNT,
    READY,
    SHIFT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MIN_CNT =
    CNT_WIDTH'(MIN_DUMMY_CLKS);

  state_t         state;
  logic [45:0]    shreg;
  logic [5:0]     bit_cnt;
  logic [6:0]     crc;
  logic           selected;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic           fb;
  logic [6:0]     crc_next;
  logic           crc_ok;
  logic           fmt_ok;
  logic [5:0]     idx;
  logic [31:0]    arg;

  assign selected = CS_ACTIVE_LOW ? !CS : CS;
  assign cnt_inc  = DummyCount + 1'b1;

  // CRC7, poly x^7 + x^3 + 1, fed MSB-first
  assign fb       = crc[6] ^ MOSI;
  assign crc_next = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};

  // On the 48th edge shreg holds frame bits 46..1, MOSI is bit 0
  assign idx    = shreg[44:39];
  assign arg    = shreg[38:7];
  assign crc_ok = (shreg[6:0] == crc);
  assign fmt_ok = shreg[45] && MOSI;

  assign IsInitialized = (state != COUNT);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state          <= COUNT;
      shreg          <= '0;
      bit_cnt        <= '0;
      crc            <= '0;
      DummyCount     <= '0;
      CmdValid       <= 1'b0;
      CmdIndex       <= '0;
      CmdArg         <= '0;
      CmdCrcOk       <= 1'b0;
      CmdError       <= 1'b0;
      FrameAbort     <= 1'b0;
      IsCmd0Received <= 1'b0;
    end else if (Rearm) begin
      state          <= COUNT;
      shreg          <= '0;
      bit_cnt        <= '0;
      crc            <= '0;
      DummyCount     <= '0;
      CmdValid       <= 1'b0;
      CmdIndex       <= '0;
      CmdArg         <= '0;
      CmdCrcOk       <= 1'b0;
      CmdError       <= 1'b0;
      FrameAbort     <= 1'b0;
      IsCmd0Received <= 1'b0;
    end else begin
      CmdValid   <= 1'b0;
      CmdError   <= 1'b0;
      FrameAbort <= 1'b0;
      unique case (state)
        COUNT: begin
          if (MOSI && !selected) begin
            DummyCount <= cnt_inc;
            if (cnt_inc == MIN_CNT) state <= READY;
          end else begin
            DummyCount <= '0;
          end
        end
        READY: begin
          if (selected && !MOSI) begin
            shreg   <= {45'b0, MOSI};
            bit_cnt <= 6'd1;
            crc     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!selected) begin
            CmdError   <= 1'b1;
            FrameAbort <= 1'b1;
            state      <= READY;
          end else if (bit_cnt == 6'd47) begin
            CmdValid <= 1'b1;
            CmdIndex <= idx;
            CmdArg   <= arg;
            CmdCrcOk <= crc_ok;
            CmdError <= !fmt_ok || (CHECK_CRC && !crc_ok);
            if (fmt_ok && crc_ok && idx == 6'd0 && arg == 32'd0)
              IsCmd0Received <= 1'b1;
            state <= READY;
          end else begin
            shreg   <= {shreg[44:0], MOSI};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt < 6'd40) crc <= crc_next;
          end
        end
        default: state <= COUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sd_init_monitor.sv
// Directed bench for spi_sd_init_monitor, with a CRC-checking
// instance and a CRC-ignoring instance on the same pins.
module tb_spi_sd_init_monitor;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        MOSI = 1'b1;
  logic        CS = 1'b1;
  logic        Rearm = 1'b0;

  logic        d_init, n_init;
  logic [7:0]  d_cnt, n_cnt;
  logic        d_valid, n_valid;
  logic [5:0]  d_idx, n_idx;
  logic [31:0] d_arg, n_arg;
  logic        d_crcok, n_crcok;
  logic        d_err, n_err;
  logic        d_abort, n_abort;
  logic        d_cmd0, n_cmd0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  spi_sd_init_monitor #(.CHECK_CRC(1'b1)) u_dut (
    .CLK(CLK), .reset_n(reset_n), .MOSI(MOSI), .CS(CS),
    .Rearm(Rearm), .IsInitialized(d_init), .DummyCount(d_cnt),
    .CmdValid(d_valid), .CmdIndex(d_idx), .CmdArg(d_arg),
    .CmdCrcOk(d_crcok), .CmdError(d_err),
    .FrameAbort(d_abort), .IsCmd0Received(d_cmd0)
  );

  spi_sd_init_monitor #(.CHECK_CRC(1'b0)) u_nocrc (
    .CLK(CLK), .reset_n(reset_n), .MOSI(MOSI), .CS(CS),
    .Rearm(Rearm), .IsInitialized(n_init), .DummyCount(n_cnt),
    .CmdValid(n_valid), .CmdIndex(n_idx), .CmdArg(n_arg),
    .CmdCrcOk(n_crcok), .CmdError(n_err),
    .FrameAbort(n_abort), .IsCmd0Received(n_cmd0)
  );

  task automatic clk_bit(input logic m, input logic c);
    MOSI = m;
    CS   = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic dummies(input int n);
    for (int i = 0; i < n; i++) clk_bit(1'b1, 1'b1);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) clk_bit(f[i], 1'b0);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({d_init, d_cnt, d_valid, d_idx, d_arg, d_crcok,
         d_err, d_abort, d_cmd0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got init=%b cnt=%0d valid=%b cmd0=%b need all 0",
               d_init, d_cnt, d_valid, d_cmd0);
    end
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic test_dummy_count;
    dummies(73);
    checks++;
    if (d_cnt !== 8'd73 || d_init !== 1'b0) begin
      errors++;
      $display("FAIL count_73 got cnt=%0d init=%b need 73/0", d_cnt, d_init);
    end
    clk_bit(1'b0, 1'b1);
    checks++;
    if (d_cnt !== 8'd0 || d_init !== 1'b0) begin
      errors++;
      $display("FAIL count_break got cnt=%0d init=%b need 0/0", d_cnt, d_init);
    end
    dummies(73);
    checks++;
    if (d_init !== 1'b0) begin
      errors++;
      $display("FAIL early_init got init=%b need 0", d_init);
    end
    dummies(1);
    checks++;
    if (d_init !== 1'b1 || d_cnt !== 8'd74) begin
      errors++;
      $display("FAIL init_74 got init=%b cnt=%0d need 1/74", d_init, d_cnt);
    end
    dummies(1);
    checks++;
    if (d_init !== 1'b1 || d_cnt !== 8'd74) begin
      errors++;
      $display("FAIL count_sat got init=%b cnt=%0d need 1/74", d_init, d_cnt);
    end
  endtask

  task automatic test_cmd0;
    send_frame(48'h400000000095);
    checks++;
    if (d_valid !== 1'b1 || d_idx !== 6'd0 || d_arg !== 32'd0 ||
        d_crcok !== 1'b1 || d_err !== 1'b0 || d_cmd0 !== 1'b1) begin
      errors++;
      $display("FAIL cmd0 got v=%b idx=%0d arg=%h ok=%b err=%b c0=%b need 1/0/0/1/0/1",
               d_valid, d_idx, d_arg, d_crcok, d_err, d_cmd0);
    end
    dummies(1);
    checks++;
    if (d_valid !== 1'b0 || d_cmd0 !== 1'b1) begin
      errors++;
      $display("FAIL cmd0_pulse got v=%b c0=%b need 0/1", d_valid, d_cmd0);
    end
  endtask

  task automatic test_cmd8;
    send_frame(48'h48000001AA87);
    checks++;
    if (d_valid !== 1'b1 || d_idx !== 6'd8 || d_arg !== 32'h000001AA ||
        d_crcok !== 1'b1 || d_err !== 1'b0 || d_cmd0 !== 1'b1) begin
      errors++;
      $display("FAIL cmd8 got v=%b idx=%0d arg=%h ok=%b err=%b c0=%b need 1/8/1aa/1/0/1",
               d_valid, d_idx, d_arg, d_crcok, d_err, d_cmd0);
    end
    dummies(2);
  endtask

  task automatic test_abort;
    logic [47:0] f;
    f = 48'h400000000095;
    for (int i = 47; i >= 28; i--) clk_bit(f[i], 1'b0);
    clk_bit(1'b1, 1'b1);
    checks++;
    if (d_abort !== 1'b1 || d_err !== 1'b1 || d_valid !== 1'b0 ||
        d_idx !== 6'd8 || d_arg !== 32'h000001AA) begin
      errors++;
      $display("FAIL abort got ab=%b err=%b v=%b idx=%0d arg=%h need 1/1/0/8/1aa",
               d_abort, d_err, d_valid, d_idx, d_arg);
    end
    dummies(1);
    checks++;
    if (d_abort !== 1'b0 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse got ab=%b err=%b need 0/0", d_abort, d_err);
    end
    send_frame(48'h400000000095);
    checks++;
    if (d_valid !== 1'b1 || d_idx !== 6'd0 || d_arg !== 32'd0 ||
        d_crcok !== 1'b1 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL post_abort got v=%b idx=%0d arg=%h ok=%b err=%b need 1/0/0/1/0",
               d_valid, d_idx, d_arg, d_crcok, d_err);
    end
    dummies(1);
  endtask

  task automatic test_bad_crc;
    send_frame(48'h400000000097);
    checks++;
    if (d_valid !== 1'b1 || d_crcok !== 1'b0 || d_err !== 1'b1 ||
        d_cmd0 !== 1'b1) begin
      errors++;
      $display("FAIL bad_crc got v=%b ok=%b err=%b c0=%b need 1/0/1/1",
               d_valid, d_crcok, d_err, d_cmd0);
    end
    checks++;
    if (n_valid !== 1'b1 || n_crcok !== 1'b0 || n_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_crc_nocheck got v=%b ok=%b err=%b need 1/0/0",
               n_valid, n_crcok, n_err);
    end
    dummies(1);
  endtask

  task automatic test_bad_end;
    send_frame(48'h400000000094);
    checks++;
    if (d_valid !== 1'b1 || d_crcok !== 1'b1 || n_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_end got v=%b ok=%b nerr=%b need 1/1/1",
               d_valid, d_crcok, n_err);
    end
    dummies(1);
  endtask

  task automatic test_reset_rearm;
    logic [47:0] f;
    f = 48'h400000000095;
    for (int i = 47; i >= 31; i--) clk_bit(f[i], 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({d_init, d_cnt, d_valid, d_idx, d_arg, d_crcok,
         d_err, d_abort, d_cmd0} !== '0) begin
      errors++;
      $display("FAIL midframe_reset got init=%b cnt=%0d idx=%0d c0=%b need all 0",
               d_init, d_cnt, d_idx, d_cmd0);
    end
    #1;
    reset_n = 1'b1;
    dummies(74);
    send_frame(48'h400000000095);
    dummies(1);
    checks++;
    if (d_init !== 1'b1 || d_cmd0 !== 1'b1) begin
      errors++;
      $display("FAIL reinit got init=%b c0=%b need 1/1", d_init, d_cmd0);
    end
    Rearm = 1'b1;
    clk_bit(1'b1, 1'b1);
    Rearm = 1'b0;
    checks++;
    if (d_init !== 1'b0 || d_cnt !== 8'd0 || d_cmd0 !== 1'b0 ||
        d_idx !== 6'd0 || d_crcok !== 1'b0) begin
      errors++;
      $display("FAIL rearm got init=%b cnt=%0d c0=%b idx=%0d ok=%b need 0/0/0/0/0",
               d_init, d_cnt, d_cmd0, d_idx, d_crcok);
    end
    dummies(73);
    checks++;
    if (d_init !== 1'b0 || d_cnt !== 8'd73) begin
      errors++;
      $display("FAIL rearm_73 got init=%b cnt=%0d need 0/73", d_init, d_cnt);
    end
    dummies(1);
    checks++;
    if (d_init !== 1'b1 || d_cnt !== 8'd74) begin
      errors++;
      $display("FAIL rearm_74 got init=%b cnt=%0d need 1/74", d_init, d_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_dummy_count;
    test_cmd0;
    test_cmd8;
    test_abort;
    test_bad_crc;
    test_bad_end;
    test_reset_rearm;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sd_init_monitor.md
Name: spi_sd_init_monitor

Overview:
Parametrised successor to the SD-over-SPI power-up stabiliser. Counts a configurable run of consecutive dummy clocks (MOSI high, card deselected) and flags the link initialised. It then frames the 48-bit SD commands that follow, checks their CRC7, and reports index and argument, plus a sticky CMD0 indication. Sits on the SPI pins of the SD slave model; CLK is the SPI SCK.

Parameters:
MIN_DUMMY_CLKS, 74, consecutive qualifying dummy clocks required before IsInitialized; must be ≥1.
CNT_WIDTH, 8, dummy counter width; must satisfy 2^CNT_WIDTH > MIN_DUMMY_CLKS.
CS_ACTIVE_LOW, 1, 1: CS low selects the card; 0: CS high selects.
CHECK_CRC, 1, 1: CRC7 mismatch is a frame error; 0: CRC is reported but never errors.

Ports:
CLK  input  1  SPI clock; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
MOSI  input  1  serial data from host.
CS  input  1  chip select, polarity per CS_ACTIVE_LOW.
Rearm  input  1  synchronous clear back to dummy counting; has priority over all other inputs.
IsInitialized  output  1  high once MIN_DUMMY_CLKS consecutive dummy clocks have been seen.
DummyCount  output  CNT_WIDTH  current consecutive dummy count; saturates at MIN_DUMMY_CLKS.
CmdValid  output  1  one-cycle pulse when a 48-bit frame completes.
CmdIndex  output  6  command index of the last frame; held until the next frame.
CmdArg  output  32  argument of the last frame; held.
CmdCrcOk  output  1  received CRC7 matched the computed CRC7 for the last frame; held.
CmdError  output  1  one-cycle pulse on a bad frame or an aborted frame.
FrameAbort  output  1  one-cycle pulse when the card is deselected mid-frame; coincides with CmdError.
IsCmd0Received  output  1  sticky; set by a valid CMD0 (index 0, arg 0, CRC ok, framing ok).

Behaviour:
- Derived signal: selected = CS_ACTIVE_LOW ? !CS : CS.
- Reset (reset_n low): state COUNT; all counters, shift register and CRC cleared; every output 0.
- Rearm=1 at a posedge has the same effect as reset, except it is synchronous.
- COUNT state:
  - Each posedge with MOSI=1 and !selected increments DummyCount; any other posedge clears it to 0.
  - When the incremented value equals MIN_DUMMY_CLKS, go to READY. IsInitialized is combinational from state==READY or later, so it is high after exactly the MIN_DUMMY_CLKS-th qualifying edge.
  - Frames are ignored in COUNT.
- READY state:
  - DummyCount holds at MIN_DUMMY_CLKS.
  - A selected posedge with MOSI=0 is the start bit: load it as bit 47, set bit counter to 1, clear CRC, go to SHIFT.
  - Selected edges with MOSI=1 are idle fill; stay in READY.
- SHIFT state:
  - Each selected posedge shifts MOSI in MSB-first.
  - The CRC7 (poly x^7+x^3+1, init 0) updates over bits 47..8, i.e. the first 40 bits.
  - On the 48th bit, go to READY in the same edge. CmdValid pulses the cycle after.
  - CmdIndex = bits[45:40]; CmdArg = bits[39:8].
  - CmdCrcOk = (bits[7:1] == CRC7).
- Frame errors: transmission bit (bit 46) ≠ 1, end bit (bit 0) ≠ 1, or (CHECK_CRC && !CmdCrcOk).
  - Any frame error makes CmdError pulse together with CmdValid.
  - Outputs are still updated on an erroneous frame.
- Abort: a !selected posedge while in SHIFT pulses CmdError and FrameAbort, discards the partial frame, and returns to READY. CmdValid stays low and the held outputs are unchanged.
- IsCmd0Received sets with a CmdValid pulse that has index 0, arg 0, CmdCrcOk=1 and no framing error. It clears only on reset or Rearm.
- The dummy counter never wraps; width overflow is prevented by the parameter constraint.
- Rearm and a frame completion on the same edge: Rearm wins; no pulses are emitted.

Test Plan:
- 73 edges MOSI=1/CS=1, then one edge MOSI=0 → IsInitialized=0, DummyCount=0. Then 74 qualifying edges → IsInitialized=1 after the 74th edge; a 75th edge leaves DummyCount=74.
- After init, CS=0, shift 0x400000000095 → CmdValid pulse, CmdIndex=0, CmdArg=0, CmdCrcOk=1, CmdError=0, IsCmd0Received=1.
- Shift 0x48000001AA87 → CmdIndex=8, CmdArg=0x000001AA, CmdCrcOk=1; IsCmd0Received stays 1.
- Shift 0x400000000097 with CHECK_CRC=1 → CmdCrcOk=0, CmdError pulse, IsCmd0Received unchanged. Same frame with CHECK_CRC=0 → CmdError=0.
- CS=0, 20 bits of CMD0, then CS=1 for one edge → FrameAbort and CmdError pulse, no CmdValid. A following full CMD0 decodes correctly.
- Drive reset_n low mid-frame (bit 30), then Rearm=1 in the ready state → all outputs 0 immediately on reset; after Rearm, IsInitialized=0 and 74 fresh dummy clocks are required.
